core_rx: RTL

Serial frame receiver for the lab link: it recovers the `NOM`/`BIT`/`LE` triple from the single-wire `TX` line driven by `core` and presents it as registered parallel fields with a one-cycle valid strobe. It sits at the far end of the link, clocked from the same `hit` clock as the sender. It oversamples the line, detects start bits, samples mid-bit, checks framing (and optionally parity) and reports errors.

---
 rtl/core_pkg.sv | 24 ++
 rtl/core_rx_sync.sv | 35 +++
 rtl/core_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the lab serial link: field widths, receiver/transmitter
// state encoding and the odd-parity helper used by both ends.
package core_pkg;

  localparam int NOM_W     = 4;
  localparam int BIT_W     = 2;
  localparam int LE_W      = 4;
  localparam int PAYLOAD_W = NOM_W + BIT_W + LE_W;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } state_t;

  // Bit that makes the total count of ones across payload plus parity odd.
  function automatic logic oddParity(input logic [PAYLOAD_W-1:0] payload);
    return ~(^payload);
  endfunction

endpackage

// File: rtl/core_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector that only
// arms once the synchronized line has genuinely been seen high after reset.
module core_rx_sync (
  input  logic hit,
  input  logic clr,
  input  logic rx_i,
  output logic rxS_o,
  output logic fallEdge_o
);

  logic       meta_q;
  logic       rxS_q;
  logic [1:0] fillPipe_q;
  logic       prevHigh_q;

  // The sync flops reset high, so a separate fill pipe tracks when rxS_q holds a
  // real sample; prevHigh_q only records a high that actually came from the line.
  always_ff @(posedge hit) begin
    if (!clr) begin
      meta_q     <= 1'b1;
      rxS_q      <= 1'b1;
      fillPipe_q <= 2'b00;
      prevHigh_q <= 1'b0;
    end else begin
      meta_q     <= rx_i;
      rxS_q      <= meta_q;
      fillPipe_q <= {fillPipe_q[0], 1'b1};
      prevHigh_q <= rxS_q & fillPipe_q[1];
    end
  end

  assign rxS_o      = rxS_q;
  assign fallEdge_o = prevHigh_q & ~rxS_q;

endmodule

// File: rtl/core_rx.sv
// Serial frame receiver recovering NOM/BIT/LE from the single-wire link.
// Optional odd-parity checking is enabled by defining CORE_RX_PARITY_EN.
module core_rx
  import core_pkg::*;
#(
  parameter int BIT_CYCLES = 16
) (
  input  logic             hit,
  input  logic             clr,
  input  logic             RX,
  output logic [NOM_W-1:0] NOM,
  output logic [BIT_W-1:0] BIT,
  output logic [LE_W-1:0]  LE,
  output logic             VALID,
  output logic             ERR,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(PAYLOAD_W - 1);

  logic rxS;
  logic fallEdge;

  core_rx_sync uSync (
    .hit        (hit),
    .clr        (clr),
    .rx_i       (RX),
    .rxS_o      (rxS),
    .fallEdge_o (fallEdge)
  );

  state_t               state_q;
  logic [CNT_W-1:0]     cycleCnt_q;
  logic [3:0]           bitCnt_q;
  logic [PAYLOAD_W-1:0] shift_q;
  logic [NOM_W-1:0]     nom_q;
  logic [BIT_W-1:0]     bit_q;
  logic [LE_W-1:0]      le_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 parFault;

`ifdef CORE_RX_PARITY_EN
  logic parErr_q;
  assign parFault = parErr_q;
`else
  assign parFault = 1'b0;
`endif

  // Whole receive FSM lives here so fields and strobes come straight off flops.
  always_ff @(posedge hit) begin
    if (!clr) begin
      state_q    <= IDLE;
      cycleCnt_q <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      nom_q      <= '0;
      bit_q      <= '0;
      le_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef CORE_RX_PARITY_EN
      parErr_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fallEdge) begin
            state_q    <= START;
            cycleCnt_q <= '0;
          end
        end
        START: begin
          if (cycleCnt_q == HALF_LAST) begin
            cycleCnt_q <= '0;
            bitCnt_q   <= '0;
            state_q    <= rxS ? IDLE : DATA;
          end else begin
            cycleCnt_q <= cycleCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cycleCnt_q == FULL_LAST) begin
            cycleCnt_q <= '0;
            shift_q    <= {rxS, shift_q[PAYLOAD_W-1:1]};
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_q <= '0;
`ifdef CORE_RX_PARITY_EN
              state_q  <= PARITY;
`else
              state_q  <= STOP;
`endif
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end else begin
            cycleCnt_q <= cycleCnt_q + 1'b1;
          end
        end
`ifdef CORE_RX_PARITY_EN
        PARITY: begin
          if (cycleCnt_q == FULL_LAST) begin
            cycleCnt_q <= '0;
            parErr_q   <= (rxS != oddParity(shift_q));
            state_q    <= STOP;
          end else begin
            cycleCnt_q <= cycleCnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cycleCnt_q == FULL_LAST) begin
            cycleCnt_q <= '0;
            if (rxS && !parFault) begin
              nom_q   <= shift_q[NOM_W-1:0];
              bit_q   <= shift_q[NOM_W+BIT_W-1:NOM_W];
              le_q    <= shift_q[PAYLOAD_W-1:NOM_W+BIT_W];
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= rxS ? IDLE : WAIT_HI;
            end
          end else begin
            cycleCnt_q <= cycleCnt_q + 1'b1;
          end
        end
        // A stop bit seen low means the line is broken or we lost sync; only a
        // return to idle-high can make the next falling edge trustworthy.
        WAIT_HI: begin
          if (rxS) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign NOM   = nom_q;
  assign BIT   = bit_q;
  assign LE    = le_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign BUSY  = (state_q != IDLE);

endmodule
